// File: rtl/otter_io_pkg.sv
// Shared register offsets and reset constants for the OTTER I/O hub.
package otter_io_pkg;

    localparam logic [31:0] OFF_SW   = 32'h0;
    localparam logic [31:0] OFF_BTN  = 32'h4;
    localparam logic [31:0] OFF_PEND = 32'h8;

    localparam logic [31:0] OFF_LEDS = 32'h0;
    localparam logic [31:0] OFF_SEGS = 32'h4;
    localparam logic [31:0] OFF_AN   = 32'h8;
    localparam logic [31:0] OFF_MASK = 32'hC;
    localparam logic [31:0] OFF_CLR  = 32'h10;

    localparam logic [7:0] SEGS_RST = 8'hFF;
    localparam logic [3:0] AN_RST   = 4'hF;

endpackage

// File: rtl/io_debounce.sv
// One button: 2-flop synchroniser, stability counter and debounced level.
// rise is combinational and is high during the cycle before the edge on which level goes 0->1.
module io_debounce #(
    parameter int DB_CYCLES = 8
) (
    input  logic clk,
    input  logic RESET_N,
    input  logic pin,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;
    logic          flip;

    // The counter would reach DB_CYCLES on this edge: toggle instead of counting.
    assign flip = (sync_2 != level) && (cnt == CNT_LAST);
    assign rise = flip && !level;

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync_1 <= pin;
            sync_2 <= sync_1;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (flip) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/otter_io_hub.sv
// Memory-mapped I/O hub: switch/button inputs, LED/7-seg outputs and a
// maskable edge-captured button interrupt for the OTTER MCU.
module otter_io_hub
    import otter_io_pkg::*;
#(
    parameter int          N_BTN      = 5,
    parameter int          N_SW       = 16,
    parameter int          N_LED      = 16,
    parameter int          DB_CYCLES  = 8,
    parameter int          INTR_PULSE = 0,
    parameter logic [31:0] BASE_IN    = 32'h11008000,
    parameter logic [31:0] BASE_OUT   = 32'h1100C000
) (
    input  logic             clk,
    input  logic             RESET_N,
    input  logic [N_BTN-1:0] buttons,
    input  logic [N_SW-1:0]  switches,
    input  logic [31:0]      IOBUS_ADDR,
    input  logic [31:0]      IOBUS_OUT,
    input  logic             IOBUS_WR,
    output logic [31:0]      IOBUS_IN,
    output logic [N_LED-1:0] leds,
    output logic [7:0]       segs,
    output logic [3:0]       an,
    output logic             INTR
);

    logic [N_SW-1:0]  sw_s1;
    logic [N_SW-1:0]  sw_s2;
    logic [N_BTN-1:0] btn_lvl;
    logic [N_BTN-1:0] btn_rise;
    logic [N_BTN-1:0] mask;
    logic [N_BTN-1:0] pend;
    logic [N_BTN-1:0] clr_bits;
    logic             irq_any;
    logic             wr_leds, wr_segs, wr_an, wr_mask, wr_clr;
    logic             unused_wdata;

    for (genvar i = 0; i < N_BTN; i++) begin : g_db
        io_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk    (clk),
            .RESET_N(RESET_N),
            .pin    (buttons[i]),
            .level  (btn_lvl[i]),
            .rise   (btn_rise[i])
        );
    end

    assign wr_leds  = IOBUS_WR && (IOBUS_ADDR == BASE_OUT + OFF_LEDS);
    assign wr_segs  = IOBUS_WR && (IOBUS_ADDR == BASE_OUT + OFF_SEGS);
    assign wr_an    = IOBUS_WR && (IOBUS_ADDR == BASE_OUT + OFF_AN);
    assign wr_mask  = IOBUS_WR && (IOBUS_ADDR == BASE_OUT + OFF_MASK);
    assign wr_clr   = IOBUS_WR && (IOBUS_ADDR == BASE_OUT + OFF_CLR);
    assign clr_bits = wr_clr ? IOBUS_OUT[N_BTN-1:0] : '0;
    assign unused_wdata = &{1'b0, IOBUS_OUT};

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
            leds  <= '0;
            segs  <= SEGS_RST;
            an    <= AN_RST;
            mask  <= '0;
            pend  <= '0;
        end else begin
            sw_s1 <= switches;
            sw_s2 <= sw_s1;
            if (wr_leds) leds <= IOBUS_OUT[N_LED-1:0];
            if (wr_segs) segs <= IOBUS_OUT[7:0];
            if (wr_an)   an   <= IOBUS_OUT[3:0];
            if (wr_mask) mask <= IOBUS_OUT[N_BTN-1:0];
            // A new rising edge beats a simultaneous clear of the same bit.
            pend <= (pend & ~clr_bits) | btn_rise;
        end
    end

    assign irq_any = |(pend & mask);

    if (INTR_PULSE != 0) begin : g_pulse
        logic irq_d;
        always_ff @(posedge clk or negedge RESET_N) begin
            if (!RESET_N) begin
                irq_d <= 1'b0;
                INTR  <= 1'b0;
            end else begin
                irq_d <= irq_any;
                INTR  <= irq_any & ~irq_d;
            end
        end
    end else begin : g_level
        always_ff @(posedge clk or negedge RESET_N) begin
            if (!RESET_N) INTR <= 1'b0;
            else          INTR <= irq_any;
        end
    end

    always_comb begin
        IOBUS_IN = '0;
        case (IOBUS_ADDR)
            BASE_IN + OFF_SW:    IOBUS_IN[N_SW-1:0]  = sw_s2;
            BASE_IN + OFF_BTN:   IOBUS_IN[N_BTN-1:0] = btn_lvl;
            BASE_IN + OFF_PEND:  IOBUS_IN[N_BTN-1:0] = pend;
            BASE_OUT + OFF_LEDS: IOBUS_IN[N_LED-1:0] = leds;
            BASE_OUT + OFF_SEGS: IOBUS_IN[7:0]       = segs;
            BASE_OUT + OFF_AN:   IOBUS_IN[3:0]       = an;
            BASE_OUT + OFF_MASK: IOBUS_IN[N_BTN-1:0] = mask;
            default:             IOBUS_IN            = '0;
        endcase
    end

endmodule

// File: tb/tb_otter_io_hub.sv
// Randomised bench for otter_io_hub: one level-mode and one pulse-mode instance
// share the same stimulus and are compared against a cycle-level model.
module tb_otter_io_hub;

    localparam int          N_BTN = 5;
    localparam int          N_SW  = 16;
    localparam int          N_LED = 16;
    localparam int          DB    = 8;
    localparam logic [31:0] BI    = 32'h11008000;
    localparam logic [31:0] BO    = 32'h1100C000;

    logic             clk = 1'b0;
    logic             RESET_N;
    logic [N_BTN-1:0] buttons;
    logic [N_SW-1:0]  switches;
    logic [31:0]      IOBUS_ADDR, IOBUS_OUT;
    logic             IOBUS_WR;
    logic [31:0]      rd_l, rd_p;
    logic [N_LED-1:0] leds_l, leds_p;
    logic [7:0]       segs_l, segs_p;
    logic [3:0]       an_l, an_p;
    logic             intr_l, intr_p;

    otter_io_hub #(.INTR_PULSE(0)) u_lvl (
        .clk(clk), .RESET_N(RESET_N), .buttons(buttons), .switches(switches),
        .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT), .IOBUS_WR(IOBUS_WR),
        .IOBUS_IN(rd_l), .leds(leds_l), .segs(segs_l), .an(an_l), .INTR(intr_l)
    );

    otter_io_hub #(.INTR_PULSE(1)) u_pls (
        .clk(clk), .RESET_N(RESET_N), .buttons(buttons), .switches(switches),
        .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT), .IOBUS_WR(IOBUS_WR),
        .IOBUS_IN(rd_p), .leds(leds_p), .segs(segs_p), .an(an_p), .INTR(intr_p)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int npulse = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // hist holds the button pins seen on the last DB+2 edges, oldest first.
    logic [N_BTN-1:0] hist[$];
    logic [N_BTN-1:0] m_lvl, m_pend, m_mask;
    logic [N_LED-1:0] m_leds;
    logic [7:0]       m_segs;
    logic [3:0]       m_an;
    logic [N_SW-1:0]  m_sw, m_sw_prev;
    logic             m_irq, m_irq_prev, m_intr_l, m_intr_p;
    logic [31:0]      exp_q[$];

    function automatic void model_reset();
        hist.delete();
        for (int k = 0; k < DB + 2; k++) hist.push_back('0);
        m_lvl = '0; m_pend = '0; m_mask = '0;
        m_leds = '0; m_segs = 8'hFF; m_an = 4'hF;
        m_sw = '0; m_sw_prev = '0;
        m_irq = 1'b0; m_irq_prev = 1'b0; m_intr_l = 1'b0; m_intr_p = 1'b0;
    endfunction

    // A button level flips once DB consecutive synchronised samples disagree with it.
    function automatic logic [N_BTN-1:0] toggles(input int first);
        logic [N_BTN-1:0] t;
        t = '0;
        for (int b = 0; b < N_BTN; b++) begin
            logic all_diff;
            all_diff = 1'b1;
            for (int k = first; k < first + DB; k++)
                if (hist[k][b] == m_lvl[b]) all_diff = 1'b0;
            t[b] = all_diff;
        end
        return t;
    endfunction

    function automatic void model_edge();
        logic [N_BTN-1:0] tog, rise, clr;
        hist.push_back(buttons);
        void'(hist.pop_front());
        tog   = toggles(0);
        rise  = tog & ~m_lvl;
        m_lvl = m_lvl ^ tog;
        clr   = '0;
        m_intr_l = m_irq;
        m_intr_p = m_irq & ~m_irq_prev;
        if (IOBUS_WR) begin
            case (IOBUS_ADDR)
                BO:          m_leds = IOBUS_OUT[N_LED-1:0];
                BO + 32'h4:  m_segs = IOBUS_OUT[7:0];
                BO + 32'h8:  m_an   = IOBUS_OUT[3:0];
                BO + 32'hC:  m_mask = IOBUS_OUT[N_BTN-1:0];
                BO + 32'h10: clr    = IOBUS_OUT[N_BTN-1:0];
                default: ;
            endcase
        end
        m_pend     = (m_pend & ~clr) | rise;
        m_irq_prev = m_irq;
        m_irq      = |(m_pend & m_mask);
        m_sw       = m_sw_prev;
        m_sw_prev  = switches;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        case (a)
            BI:          return 32'(m_sw);
            BI + 32'h4:  return 32'(m_lvl);
            BI + 32'h8:  return 32'(m_pend);
            BO:          return 32'(m_leds);
            BO + 32'h4:  return 32'(m_segs);
            BO + 32'h8:  return 32'(m_an);
            BO + 32'hC:  return 32'(m_mask);
            default:     return 32'h0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rd_addr);
        IOBUS_WR   = wr;
        IOBUS_ADDR = addr;
        IOBUS_OUT  = data;
        @(posedge clk);
        model_edge();
        #1;
        check("intr_level", intr_l, m_intr_l);
        check("intr_pulse", intr_p, m_intr_p);
        check("leds", leds_l, m_leds);
        check("segs", segs_l, m_segs);
        check("an", an_l, m_an);
        if (intr_p) npulse++;
        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = rd_addr;
        #1;
        exp_q.push_back(model_read(rd_addr));
        check($sformatf("rd_pulse@%h", rd_addr), rd_p, exp_q[0]);
        check($sformatf("rd@%h", rd_addr), rd_l, exp_q.pop_front());
    endtask

    task automatic idle(input int n, input logic [31:0] rd_addr);
        repeat (n) cycle(1'b0, 32'h0, 32'h0, rd_addr);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        RESET_N = 1'b0;
        #1;
        check("rst_leds", leds_l, 32'h0);
        check("rst_segs", segs_l, 32'hFF);
        check("rst_an", an_l, 32'hF);
        check("rst_intr_l", intr_l, 32'h0);
        check("rst_intr_p", intr_p, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        RESET_N = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] wr_addrs[8];
    logic [31:0] rd_addrs[10];

    initial begin
        logic [N_BTN-1:0] t;
        int guard;

        wr_addrs = '{BO, BO + 32'h4, BO + 32'h8, BO + 32'hC, BO + 32'h10, BO + 32'h20,
                     BI, BI + 32'h4};
        rd_addrs = '{BI, BI + 32'h4, BI + 32'h8, BI + 32'hC, BO, BO + 32'h4, BO + 32'h8,
                     BO + 32'hC, BO + 32'h10, BO + 32'h14};
        RESET_N = 1'b0; buttons = '0; switches = '0;
        IOBUS_WR = 1'b0; IOBUS_ADDR = '0; IOBUS_OUT = '0;
        model_reset();
        do_reset();

        // Reset state readback
        cycle(1'b0, 32'h0, 32'h0, BI + 32'h8);
        check("pend_after_rst", rd_l, 32'h0);
        cycle(1'b0, 32'h0, 32'h0, BO + 32'hC);
        check("mask_after_rst", rd_l, 32'h0);

        // Register write / readback, unmapped write ignored
        cycle(1'b1, BO, 32'hDEADBEEF, BO);
        check("leds_wb", rd_l, 32'h0000BEEF);
        cycle(1'b1, BO + 32'h4, 32'h1A5, BO + 32'h4);
        check("segs_wb", rd_l, 32'h000000A5);
        cycle(1'b1, BO + 32'h8, 32'h7, BO + 32'h8);
        check("an_wb", rd_l, 32'h7);
        cycle(1'b1, BO + 32'h20, 32'h0, BO);
        check("unmapped_wr", {leds_l, segs_l, an_l, 4'h0}, {16'hBEEF, 8'hA5, 4'h7, 4'h0});

        // Switch sync
        switches = 16'h5A3C;
        idle(3, BI);
        check("switches", rd_l, 32'h5A3C);

        // 7-cycle glitch on button 2 never changes BTN
        buttons[2] = 1'b1;
        idle(7, BI + 32'h4);
        buttons[2] = 1'b0;
        idle(12, BI + 32'h4);
        check("glitch_btn", rd_l, 32'h0);
        cycle(1'b0, 32'h0, 32'h0, BI + 32'h8);
        check("glitch_pend", rd_l, 32'h0);

        // Stable press: BTN[2] rises 9 edges after the first sampling edge
        buttons[2] = 1'b1;
        idle(9, BI + 32'h4);
        check("btn_lat_early", rd_l, 32'h0);
        idle(1, BI + 32'h4);
        check("btn_lat", rd_l, 32'h4);
        idle(1, BI + 32'h8);
        check("pend_set", rd_l, 32'h4);

        // Level interrupt: masked, unmask, clear
        check("intr_masked", intr_l, 32'h0);
        cycle(1'b1, BO + 32'hC, 32'h4, BI + 32'h8);
        idle(1, BI + 32'h8);
        check("intr_on", intr_l, 32'h1);
        cycle(1'b1, BO + 32'h10, 32'h4, BI + 32'h8);
        check("intr_hold", intr_l, 32'h1);
        idle(1, BI + 32'h8);
        check("intr_off", intr_l, 32'h0);

        // Set/clear race on button 0
        buttons[0] = 1'b1;
        guard = 0;
        t = toggles(1);
        while (!t[0] && guard < 40) begin
            idle(1, BI + 32'h8);
            t = toggles(1);
            guard++;
        end
        check("race_wait", 32'(guard < 40), 32'h1);
        cycle(1'b1, BO + 32'h10, 32'h1, BI + 32'h8);
        check("race_pend0", 32'(rd_l[0]), 32'h1);

        // Pulse mode: two events without a clear give one pulse
        buttons = '0;
        idle(14, BI + 32'h4);
        cycle(1'b1, BO + 32'h10, 32'h1F, BI + 32'h8);
        cycle(1'b1, BO + 32'hC, 32'h3, BI + 32'hC);
        idle(2, BI + 32'h8);
        npulse = 0;
        buttons[0] = 1'b1;
        idle(14, BI + 32'h8);
        buttons[1] = 1'b1;
        idle(14, BI + 32'h8);
        check("one_pulse", 32'(npulse), 32'h1);
        cycle(1'b1, BO + 32'h10, 32'h3, BI + 32'h8);
        npulse = 0;
        buttons[1] = 1'b0;
        idle(14, BI + 32'h4);
        buttons[1] = 1'b1;
        idle(14, BI + 32'h8);
        check("second_pulse", 32'(npulse), 32'h1);

        // Random traffic with a reset in the middle
        for (int i = 0; i < 400; i++) begin
            logic        wr;
            logic [31:0] wa, wd;
            if (i == 200) do_reset();
            if ($urandom_range(9) == 0) buttons[$urandom_range(N_BTN - 1)] ^= 1'b1;
            if ($urandom_range(6) == 0) switches = N_SW'($urandom);
            wr = ($urandom_range(3) == 0);
            wa = wr_addrs[$urandom_range(7)];
            wd = $urandom;
            cycle(wr, wa, wd, rd_addrs[$urandom_range(9)]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
